gray_counter_ud: RTL and testbench
==================================

Name: gray_counter_ud

Overview:
Parametrised N-bit Gray-code up/down counter. It is the successor to the fixed-width up-only Gray counter used in the lab datapath. It adds direction control, synchronous parallel load, wrap/saturate modes, a registered binary view and a terminal-count pulse. It sits beside clock-enable pulse generators and feeds display and pointer logic that needs single-bit-change sequences.

Parameters:
N, 4, counter width in bits (legal range 2..16)
RST_BIN, 0, binary value loaded on reset; the register holds its Gray equivalent

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clk_en  input  1  count-enable pulse; one step per cycle while high
up_dn  input  1  direction: 1 = increment, 0 = decrement (binary order)
sat_mode  input  1  1 = saturate at the ends, 0 = wrap around
load  input  1  synchronous parallel load strobe
load_gray  input  N  Gray-coded value captured on load
gray_out  output  N  current Gray state (registered)
bin_out  output  N  binary equivalent of gray_out (registered, same cycle)
tc  output  1  terminal-count pulse (registered)
at_max  output  1  combinational: bin_out == 2^N-1
at_min  output  1  combinational: bin_out == 0

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset (rst=1 at the edge): gray_out = RST_BIN ^ (RST_BIN>>1), bin_out = RST_BIN, tc = 0. rst overrides load and clk_en.
- Priority per edge: rst > load > clk_en > hold.
- Load: gray_out <= load_gray. bin_out <= Gray-to-binary of load_gray, where b[N-1] = g[N-1] and b[i] = b[i+1]^g[i]. tc <= 0. A clk_en pulse in the same cycle is ignored.
- Count step (clk_en=1, no load): next_bin = bin_out ± 1 in modulo-2^N arithmetic. gray_out <= next_bin ^ (next_bin>>1). bin_out <= next_bin.
  - Latency: outputs reflect the step one cycle after the enabled edge.
  - Exactly one bit of gray_out changes per step, including at wrap.
- Wrap mode (sat_mode=0):
  - Up at 2^N-1 goes to 0.
  - Down at 0 goes to 2^N-1.
  - tc = 1 for exactly the one cycle following the wrapping edge, else 0.
- Saturate mode (sat_mode=1):
  - Up at 2^N-1 or down at 0 leaves state unchanged.
  - tc = 1 for the cycle following each blocked step attempt, so it stays high while the attempts continue.
- clk_en=0 and no load: state holds, tc <= 0.
- up_dn and sat_mode are sampled only on enabled edges and may change on any cycle.
- Reset asserted mid-count: the state is restored on that edge and no tc is generated.
- Internal invariant (for assertions): gray_out == bin_out ^ (bin_out>>1) at all times after the first reset.
- X on inputs before the first reset is don't-care. The bench always applies reset first.

Test Plan:
- N=4, RST_BIN=0, rst for 2 cycles -> gray_out=0000, bin_out=0, tc=0, at_min=1.
- Up, wrap mode, 16 clk_en pulses from 0 -> gray sequence 0000,0001,0011,0010,0110,…,1000,0000. Each transition changes one bit. tc=1 only in the cycle after the 15→0 step.
- Load load_gray=0111 with clk_en=1 in the same cycle -> gray_out=0111, bin_out=5, tc=0. Next up step -> gray_out=0101, bin_out=6.
- Down, wrap mode, from 0 -> gray_out=1000, bin_out=15, tc=1 for one cycle. Next down -> 1001 (14), tc=0.
- Saturate mode, up at bin 15 with 3 enabled pulses -> gray_out stays 1000, tc high for 3 cycles. Then down at 0 with 1 pulse -> stays 0000, tc=1 for 1 cycle.
- rst asserted while counting up at bin 10 (gray 1111) with RST_BIN=3 -> next edge gray_out=0010, bin_out=3, tc=0. Random up_dn/clk_en/load for 10k cycles -> invariant and one-bit-change checks never fail.

Source files
------------

// File: rtl/gray_counter_ud.sv
// gray_counter_ud: N-bit Gray-code up/down counter with load, wrap/saturate modes,
// a registered binary view and a terminal-count pulse.
module gray_counter_ud #(
    parameter int N       = 4,
    parameter int RST_BIN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         sat_mode,
    input  logic         load,
    input  logic [N-1:0] load_gray,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         tc,
    output logic         at_max,
    output logic         at_min
);
    localparam logic [N-1:0] RST_B = RST_BIN[N-1:0];
    localparam logic [N-1:0] RST_G = RST_B ^ (RST_B >> 1);

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [N-1:0] step_bin;
    logic         at_end;
    logic         blocked;
    logic         wrapping;

    assign at_max   = &bin_out;
    assign at_min   = ~|bin_out;
    assign at_end   = up_dn ? at_max : at_min;
    assign blocked  = sat_mode & at_end;
    assign wrapping = ~sat_mode & at_end;
    assign step_bin = up_dn ? bin_out + 1'b1 : bin_out - 1'b1;

    // Binary and Gray views are updated together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_out <= RST_G;
            bin_out  <= RST_B;
            tc       <= 1'b0;
        end else if (load) begin
            gray_out <= load_gray;
            bin_out  <= g2b(load_gray);
            tc       <= 1'b0;
        end else if (clk_en) begin
            if (!blocked) begin
                gray_out <= step_bin ^ (step_bin >> 1);
                bin_out  <= step_bin;
            end
            tc <= blocked | wrapping;
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gray_counter_ud.sv
// tb_gray_counter_ud: scoreboard bench comparing two counter instances (reset values 0 and 3)
// against an integer reference model under directed and random stimulus.
module tb_gray_counter_ud;
    localparam int N   = 4;
    localparam int MAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         up_dn = 1'b0;
    logic         sat_mode = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_gray = '0;
    logic [N-1:0] gray0, bin0, gray1, bin1;
    logic         tc0, tc1, at_max0, at_min0, at_max1, at_min1;

    gray_counter_ud #(.N(N), .RST_BIN(0)) u_dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_gray(load_gray), .gray_out(gray0), .bin_out(bin0),
        .tc(tc0), .at_max(at_max0), .at_min(at_min0)
    );

    gray_counter_ud #(.N(N), .RST_BIN(3)) u_dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_gray(load_gray), .gray_out(gray1), .bin_out(bin1),
        .tc(tc1), .at_max(at_max1), .at_min(at_min1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int b0, t0, b1, t1;
        bit st0, st1;
    } exp_t;

    exp_t q[$];
    exp_t em;
    int checks = 0;
    int errors = 0;
    int m0 = 0, m1 = 3, tcm0 = 0, tcm1 = 0;
    bit st0, st1;
    logic [N-1:0] prev0 = '0, prev1 = '0;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int bin_of_gray(input int g);
        for (int b = 0; b <= MAX; b++) if (gray_of(b) == g) return b;
        return -1;
    endfunction

    task automatic advance(inout int m, inout int t, output bit stepped, input int rv);
        stepped = 1'b0;
        if (rst) begin
            m = rv;
            t = 0;
        end else if (load) begin
            m = bin_of_gray(int'(load_gray));
            t = 0;
        end else if (clk_en) begin
            if ((up_dn && m == MAX) || (!up_dn && m == 0)) begin
                t = 1;
                if (!sat_mode) begin
                    m = up_dn ? 0 : MAX;
                    stepped = 1'b1;
                end
            end else begin
                m = up_dn ? m + 1 : m - 1;
                t = 0;
                stepped = 1'b1;
            end
        end else begin
            t = 0;
        end
    endtask

    task automatic drive(input bit r, e, u, s, l, input int lg);
        @(negedge clk);
        rst = r; clk_en = e; up_dn = u; sat_mode = s; load = l;
        load_gray = lg[N-1:0];
        advance(m0, tcm0, st0, 0);
        advance(m1, tcm1, st1, 3);
        q.push_back('{m0, tcm0, m1, tcm1, st0, st1});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                em = q.pop_front();
                check("gray0", 32'(gray0), gray_of(em.b0));
                check("bin0", 32'(bin0), em.b0);
                check("tc0", 32'(tc0), em.t0);
                check("at_max0", 32'(at_max0), 32'(em.b0 == MAX));
                check("at_min0", 32'(at_min0), 32'(em.b0 == 0));
                check("inv0", 32'(gray0), 32'(bin0 ^ (bin0 >> 1)));
                if (em.st0) check("onebit0", $countones(gray0 ^ prev0), 1);
                check("gray1", 32'(gray1), gray_of(em.b1));
                check("bin1", 32'(bin1), em.b1);
                check("tc1", 32'(tc1), em.t1);
                check("at_max1", 32'(at_max1), 32'(em.b1 == MAX));
                check("at_min1", 32'(at_min1), 32'(em.b1 == 0));
                if (em.st1) check("onebit1", $countones(gray1 ^ prev1), 1);
                prev0 = gray0;
                prev1 = gray1;
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (16) drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 7);
        drive(0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 8);
        repeat (3) drive(0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 15);
        drive(1, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        repeat (10000)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, int'($urandom_range(0, MAX)));
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        check("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
